fpu_mant_mult: RTL and testbench
================================

Name: fpu_mant_mult

Overview:
- Iterative shift-add mantissa multiplier. It produces the 48-bit significand product that the FPU's multiply path consumes as its mult_result operand.
- Accepts two IEEE-754 single-precision operands and inserts the hidden bit: 1 for normal operands, 0 for exponent==0.
- Multiplies the two 24-bit significands over WIDTH/STEP cycles.
- Holds the product stable with a busy/done handshake, so the execute stage can stall until the product is ready.

Parameters:
- WIDTH, 24, significand width including hidden bit; product is 2*WIDTH bits.
- STEP, 1, multiplier bits retired per cycle; must divide WIDTH (legal: 1, 2, 3, 4, 6, 8, 12, 24).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request: sample opa/opb and begin a multiply.
- opa  input  32  single-precision operand A; sign and exponent ignored except exponent==0 test.
- opb  input  32  single-precision operand B; same treatment as opa.
- mult_result  output  2*WIDTH  unsigned significand product, {hidA,fracA} * {hidB,fracB}.
- busy  output  1  high while a multiply is in flight.
- done  output  1  one-cycle pulse when mult_result becomes valid.

Behaviour:
- Reset (async, rst=1) drives the following, regardless of current state; an in-flight multiply is discarded with no done pulse:
  - state=IDLE, counter=0, accumulator=0, mult_result=0, busy=0, done=0.
- Operand formation on the start edge:
  - mA = {(opa[30:23]!=0), opa[22:0]}; mB likewise from opb.
  - mA goes into the multiplicand register (zero-extended to 2*WIDTH bits); mB goes into the multiplier shift register.
- States:
  - IDLE: busy=0, done=0. start=1 -> RUN.
  - RUN: busy=1.
    - Each edge adds (multiplicand << k) for each of the STEP low multiplier bits k that is set.
    - Then shifts the multiplicand left by STEP and the multiplier right by STEP, and increments the counter.
    - When the counter reaches WIDTH/STEP-1 on an edge: the final sum is written to mult_result and the state goes to DONE.
  - DONE: done=1 and busy=0 for exactly this cycle. Next edge -> IDLE, or -> RUN if start=1.
- Latency:
  - With start high at edge E0, busy=1 from E0 through E(N-1), where N=WIDTH/STEP (default N=24).
  - done=1 and mult_result is valid after edge EN.
  - Next start is accepted at EN, i.e. back-to-back with no idle cycle.
- mult_result holding:
  - Changes only at the completing edge of a multiply or at reset.
  - Holds its value through IDLE and through the whole next RUN, so a downstream combinational consumer never sees partial sums.
- start while RUN (operands changed mid-flight): restart.
  - Re-sample opa/opb, clear the accumulator and counter, stay in RUN.
  - Full N-cycle latency counts from this edge; no done pulse for the abandoned operation.
- start while DONE: accepted as a new operation; done is still high for that cycle only.
- start held high continuously: the block restarts every cycle and never completes. The issuing stage must deassert start after one cycle unless operands change.
- Zero operand (mA==0 or mB==0): still takes the full N cycles; result=0. No early termination.
- Arithmetic:
  - Unsigned; the accumulator is 2*WIDTH bits and cannot overflow, since max product (2^WIDTH-1)^2 < 2^(2*WIDTH).
  - Sign, exponent, rounding and special values (Inf/NaN) are handled downstream, not here.

Test Plan:
- Reset, then opa=opb=0x3F800000 (1.0), start pulse -> busy high 24 cycles; done pulse after edge E24; mult_result=48'h4000_0000_0000.
- opa=opb=0x3FC00000 (1.5) -> 48'h9000_0000_0000. Then, back-to-back in the DONE cycle, opa=opb=0x3FFFFFFF -> 48'hFFFF_FE00_0001 exactly 24 cycles later. Previous result is held until then.
- opa=0x00000001 (denormal, hidden=0), opb=0x3F800000 -> 48'h0000_0080_0000.
- Start 1.0*1.0, then at cycle 10 start with 1.5*1.5 -> no done at cycle 24; single done at cycle 34 with 48'h9000_0000_0000. mult_result keeps its old value until then.
- Assert rst asynchronously (mid-cycle) at cycle 5 of a multiply -> busy, done and mult_result go to 0 immediately with no clock edge. A start after release completes normally.
- Rerun the 1.5*1.5 scenario with STEP=4 and STEP=24 -> latency 6 and 1 cycles; identical products.

Source files
------------

// File: rtl/fpu_mant_mult.sv
// Iterative shift-add multiplier for the two 24-bit single-precision significands.
// Retires STEP multiplier bits per cycle and holds the 2*WIDTH-bit product until the next completion.
module fpu_mant_mult #(
    parameter int WIDTH = 24,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          opa,
    input  logic [31:0]          opb,
    output logic [2*WIDTH-1:0]   mult_result,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_o
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Valid/ready: start is always accepted (restart in RUN, new op in DONE);
    // done pulses for one cycle when mult_result changes, busy covers the run.

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      acc_q;
    logic [PW-1:0]      acc_d;
    logic [PW-1:0]      mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [PW-1:0]      result_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic               unused_sign;

    // Hidden bit is 0 only for zero/denormal exponents.
    assign ma = {(opa[30:23] != 8'd0), opa[22:0]};
    assign mb = {(opb[30:23] != 8'd0), opb[22:0]};
    assign unused_sign = opa[31] ^ opb[31];

    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < STEP; k++) begin
            if (mplier_q[k]) begin
                acc_d = acc_d + (mcand_q << k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= PW'(ma);
            mplier_q <= mb;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << STEP;
                    mplier_q <= mplier_q >> STEP;
                    cnt_q    <= cnt_q + 1'b1;
                    // result_q only moves here, so consumers never see partial sums
                    if (cnt_q == LAST) begin
                        result_q <= acc_d;
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mult_result = result_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_fpu_mant_mult.sv
// Randomized and directed bench for fpu_mant_mult against an arithmetic product model.
// Extra instances with STEP=4 and STEP=24 confirm the latency scaling.
module tb_fpu_mant_mult;

    localparam int W  = 48;
    localparam int NL = 24;

    logic          clk;
    logic          rst;
    logic          start;
    logic          start4;
    logic          start24;
    logic [31:0]   opa;
    logic [31:0]   opb;
    logic [W-1:0]  mult_result;
    logic          busy;
    logic          done;
    logic [1:0]    state_o;
    logic [W-1:0]  res4;
    logic          busy4;
    logic          done4;
    logic [1:0]    state4;
    logic [W-1:0]  res24;
    logic          busy24;
    logic          done24;
    logic [1:0]    state24;

    int            n_checks;
    int            n_errors;
    logic [W-1:0]  prev_res;
    logic [W-1:0]  exp_q[$];

    fpu_mant_mult #(.WIDTH(24), .STEP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .opa(opa), .opb(opb),
        .mult_result(mult_result), .busy(busy), .done(done), .state_o(state_o)
    );

    fpu_mant_mult #(.WIDTH(24), .STEP(4)) dut_s4 (
        .clk(clk), .rst(rst), .start(start4), .opa(opa), .opb(opb),
        .mult_result(res4), .busy(busy4), .done(done4), .state_o(state4)
    );

    fpu_mant_mult #(.WIDTH(24), .STEP(24)) dut_s24 (
        .clk(clk), .rst(rst), .start(start24), .opa(opa), .opb(opb),
        .mult_result(res24), .busy(busy24), .done(done24), .state_o(state24)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // reference model: plain integer product of the hidden-bit significands
    function automatic logic [W-1:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint unsigned sa;
        longint unsigned sb;
        sa = ((a[30:23] != 8'd0) ? 64'd8388608 : 64'd0) + 64'(a[22:0]);
        sb = ((b[30:23] != 8'd0) ? 64'd8388608 : 64'd0) + 64'(b[22:0]);
        return W'(sa * sb);
    endfunction

    // driver: present operands with start for one edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        opa   = a;
        opb   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // wait for done after the accepting edge, checking the held result meanwhile
    task automatic wait_done(input string tag, input logic [W-1:0] expv);
        int  lat;
        int  busy_cnt;
        bit  held_ok;
        lat      = 0;
        busy_cnt = 0;
        held_ok  = 1'b1;
        while (!done && lat < NL + 8) begin
            if (busy) busy_cnt++;
            if (mult_result !== prev_res) held_ok = 1'b0;
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(NL));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(NL));
        check({tag, "_held"}, 64'(held_ok), 64'd1);
        check({tag, "_result"}, 64'(mult_result), 64'(expv));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        prev_res = expv;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        issue(a, b);
        wait_done(tag, ref_mult(a, b));
    endtask

    initial begin
        int          lat4;
        int          lat24;
        bit          early_done;
        logic [31:0] a;
        logic [31:0] b;
        logic [W-1:0] e;

        n_checks = 0;
        n_errors = 0;
        prev_res = '0;
        rst      = 1'b1;
        start    = 1'b0;
        start4   = 1'b0;
        start24  = 1'b0;
        opa      = 32'h0;
        opb      = 32'h0;
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(mult_result), 64'd0);
        check("reset_state", 64'(state_o), 64'd0);
        rst = 1'b0;
        tick();

        // 1.0 * 1.0
        run_op("one_x_one", 32'h3F80_0000, 32'h3F80_0000);
        check("one_x_one_const", 64'(mult_result), 64'h4000_0000_0000);
        tick();
        check("done_pulse_width", 64'(done), 64'd0);
        check("result_held_idle", 64'(mult_result), 64'h4000_0000_0000);
        check("idle_state", 64'(state_o), 64'd0);

        // 1.5 * 1.5, then back-to-back in the DONE cycle
        run_op("one5_sq", 32'h3FC0_0000, 32'h3FC0_0000);
        check("one5_sq_const", 64'(mult_result), 64'h9000_0000_0000);
        run_op("max_sig", 32'h3FFF_FFFF, 32'h3FFF_FFFF);
        check("max_sig_const", 64'(mult_result), 64'hFFFF_FE00_0001);
        tick();

        // denormal has no hidden bit
        run_op("denorm", 32'h0000_0001, 32'h3F80_0000);
        check("denorm_const", 64'(mult_result), 64'h0000_0080_0000);
        tick();

        // zero operand still takes the full latency
        run_op("zero_op", 32'h0000_0000, 32'h4049_0FDB);
        tick();

        // restart mid-flight: no done for the abandoned 1.0*1.0
        issue(32'h3F80_0000, 32'h3F80_0000);
        early_done = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (done) early_done = 1'b1;
            tick();
        end
        issue(32'h3FC0_0000, 32'h3FC0_0000);
        check("restart_no_early_done", 64'(early_done), 64'd0);
        wait_done("restart", 48'h9000_0000_0000);
        tick();

        // asynchronous reset mid-multiply
        issue(32'h3FC0_0000, 32'h3F80_0000);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        check("async_rst_result", 64'(mult_result), 64'd0);
        #1 rst = 1'b0;
        prev_res = '0;
        tick();
        run_op("after_rst", 32'h3FC0_0000, 32'h3F80_0000);
        tick();

        // randomized operands, optional restarts and back-to-back issue
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a[30:23] = 8'd0;
            if ($urandom_range(0, 3) == 0) b[30:23] = 8'd0;
            issue(a, b);
            exp_q.push_back(ref_mult(a, b));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 20)) tick();
                void'(exp_q.pop_back());
                a = $urandom;
                b = $urandom;
                issue(a, b);
                exp_q.push_back(ref_mult(a, b));
            end
            e = exp_q.pop_front();
            wait_done("rand", e);
            if ($urandom_range(0, 1) == 0) tick();
        end

        // latency scaling with STEP
        opa     = 32'h3FC0_0000;
        opb     = 32'h3FC0_0000;
        start4  = 1'b1;
        start24 = 1'b1;
        tick();
        start4  = 1'b0;
        start24 = 1'b0;
        lat4    = -1;
        lat24   = -1;
        for (int c = 0; c < 30; c++) begin
            if (done4 && lat4 < 0) lat4 = c;
            if (done24 && lat24 < 0) lat24 = c;
            if (c == 1) check("s24_result", 64'(res24), 64'h9000_0000_0000);
            if (c == 6) check("s4_result", 64'(res4), 64'h9000_0000_0000);
            tick();
        end
        check("s4_latency", 64'(lat4), 64'd6);
        check("s24_latency", 64'(lat24), 64'd1);
        check("s4_held", 64'(res4), 64'h9000_0000_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
